cpu_datapath: RTL

//  Datapath/responder side of the 8-opcode controller interface. Consumes the controller's
//  per-phase strobes (sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr).

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/cpu_alu.sv | 28 ++
 rtl/cpu_datapath.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, phase and width definitions for the CPU datapath
package cpu_pkg;

    localparam int AWIDTH_DEF = 5;
    localparam int DWIDTH_DEF = 8;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    localparam logic [2:0] PH_0 = 3'd0;
    localparam logic [2:0] PH_1 = 3'd1;
    localparam logic [2:0] PH_2 = 3'd2;
    localparam logic [2:0] PH_3 = 3'd3;
    localparam logic [2:0] PH_4 = 3'd4;
    localparam logic [2:0] PH_5 = 3'd5;
    localparam logic [2:0] PH_6 = 3'd6;
    localparam logic [2:0] PH_7 = 3'd7;

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational accumulator ALU
//  opcode  in   3       current instruction opcode
//  acc     in   DWIDTH  accumulator value
//  bus     in   DWIDTH  internal data bus value
//  result  out  DWIDTH  next accumulator value (acc when the opcode has no ALU effect)
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic [2:0]        opcode,
    input  logic [DWIDTH-1:0] acc,
    input  logic [DWIDTH-1:0] bus,
    output logic [DWIDTH-1:0] result
);

    always_comb begin
        result = acc;
        case (opcode)
            OP_ADD:  result = acc + bus;   // carry out is discarded
            OP_AND:  result = acc & bus;
            OP_XOR:  result = acc ^ bus;
            OP_LDA:  result = bus;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - CPU datapath: phase counter, PC, IR, ACC, ALU, address/bus muxes
//  clk, rst                      clock, synchronous active-high reset
//  sel/rd/ld_ir/inc_pc/halt      controller strobes
//  ld_pc/data_e/ld_ac/wr         controller strobes
//  opcode, phase, zero           status back to the controller
//  mem_addr/mem_rd/mem_wr        single-port memory control
//  mem_wdata, mem_rdata          memory write / combinational read data
//  halted, bus_err               sticky status flags
//  pc_q, acc_q                   debug views of PC and ACC
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rd,
    input  logic              ld_ir,
    input  logic              inc_pc,
    input  logic              halt,
    input  logic              ld_pc,
    input  logic              data_e,
    input  logic              ld_ac,
    input  logic              wr,
    output logic [2:0]        opcode,
    output logic [2:0]        phase,
    output logic              zero,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              halted,
    output logic              bus_err,
    output logic [AWIDTH-1:0] pc_q,
    output logic [DWIDTH-1:0] acc_q
);

    logic [DWIDTH-1:0] ir_q;
    logic [DWIDTH-1:0] bus;
    logic [DWIDTH-1:0] alu_result;
    logic [AWIDTH-1:0] ir_addr;

    assign ir_addr = ir_q[AWIDTH-1:0];
    assign opcode  = ir_q[DWIDTH-1:AWIDTH];
    assign zero    = (acc_q == '0);

    // Memory read wins over the accumulator when both drive the bus.
    assign bus       = rd ? mem_rdata : (data_e ? acc_q : '0);
    assign mem_addr  = sel ? pc_q : ir_addr;
    assign mem_wdata = data_e ? acc_q : '0;
    assign mem_rd    = rd & ~halted;
    assign mem_wr    = wr & ~halted;

    cpu_alu #(
        .DWIDTH(DWIDTH)
    ) u_alu (
        .opcode(opcode),
        .acc   (acc_q),
        .bus   (bus),
        .result(alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= PH_0;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            halted  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (rd && data_e) begin
                bus_err <= 1'b1;
            end
            if (!halted) begin
                // On the halt edge the phase freezes but PC still honours inc_pc.
                if (halt) begin
                    halted <= 1'b1;
                end else begin
                    phase <= phase + 3'd1;
                end
                if (ld_pc) begin
                    pc_q <= ir_addr;
                end else if (inc_pc) begin
                    pc_q <= pc_q + AWIDTH'(1);
                end
                if (ld_ir) begin
                    ir_q <= bus;
                end
                if (ld_ac) begin
                    acc_q <= alu_result;
                end
            end
        end
    end

endmodule
